// File: rtl/adder_tree_arbiter.sv
// Round-robin (or fixed-priority) arbiter feeding a shared 2-stage, 8-operand adder tree.
// Define ADDER_TREE_ARB_RR_EN for round-robin; otherwise lowest index wins and no pointer is built.
module adder_tree_arbiter #(
  parameter int ADDER_WIDTH = 8,
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*8*ADDER_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             res_valid,
  output logic [ADDER_WIDTH+2:0]           res_data,
  output logic [ID_W-1:0]                  res_id,
  input  logic                             res_ready
);

  localparam int W = ADDER_WIDTH;
  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid/data are held by the source until that edge, ready may depend on valid.
  logic                adv;
  logic                accept;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  rot;
  logic [ID_W-1:0]     off;
  logic                found;
  logic [ID_W:0]       gid_sum;
  logic [ID_W-1:0]     gid;
  logic [NUM_REQ-1:0]  grant;
  logic [W-1:0]        sel_op [8];

  logic                s0_valid;
  logic [ID_W-1:0]     s0_id;
  logic [W-1:0]        s0_op [8];

  logic [W:0]          l1 [4];
  logic [W+1:0]        l2 [2];
  logic [W+2:0]        l3;

  assign adv = !res_valid || res_ready;

  // Rotate so the pointer's requester sits at bit 0, pick the lowest set bit,
  // then rotate the offset back into an absolute requester index.
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = ID_W'(k);
        found = 1'b1;
      end
    end
    gid_sum = {1'b0, ptr} + {1'b0, off};
    gid     = (gid_sum >= NREQ) ? ID_W'(gid_sum - NREQ) : gid_sum[ID_W-1:0];
    grant   = found ? (NUM_REQ'(1) << gid) : '0;
  end

  assign req_ready = grant & {NUM_REQ{adv & rst_n}};
  assign accept    = |req_ready;

  always_comb begin
    for (int j = 0; j < 8; j++) sel_op[j] = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (grant[i]) sel_op[j] = req_data[(i*8+j)*W +: W];
      end
    end
  end

`ifdef ADDER_TREE_ARB_RR_EN
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gid == LAST_ID) ? '0 : gid + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_id    <= '0;
      for (int j = 0; j < 8; j++) s0_op[j] <= '0;
    end else if (adv) begin
      s0_valid <= accept;
      if (accept) begin
        s0_id <= gid;
        for (int j = 0; j < 8; j++) s0_op[j] <= sel_op[j];
      end
    end
  end

  // Each level widens by one bit, so the final sum can never overflow.
  always_comb begin
    for (int k = 0; k < 4; k++) l1[k] = {1'b0, s0_op[2*k]} + {1'b0, s0_op[2*k+1]};
    for (int k = 0; k < 2; k++) l2[k] = {1'b0, l1[2*k]} + {1'b0, l1[2*k+1]};
    l3 = {1'b0, l2[0]} + {1'b0, l2[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (adv) begin
      res_valid <= s0_valid;
      res_data  <= l3;
      res_id    <= s0_id;
    end
  end

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Bench for adder_tree_arbiter: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_adder_tree_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int SW  = W + 3;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*8*W-1:0]   req_data;
  logic [N-1:0]       req_ready;
  logic               res_valid;
  logic [SW-1:0]      res_data;
  logic [IDW-1:0]     res_id;
  logic               res_ready;

  adder_tree_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // requester-side state and reference model
  logic [W-1:0]       ops [N][8];
  logic [N-1:0]       pending;
  logic [SW+IDW-1:0]  exp_q [$];
  bit                 m_s0_v;
  bit                 m_out_v;
  int                 m_ptr;
  int                 last_grant;

  typedef struct {
    int           r;
    logic [W-1:0] op [8];
    logic [SW-1:0] exp_sum;
  } vec_t;
  vec_t vecs [5];

  logic [SW-1:0]  held_d;
  logic [IDW-1:0] held_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) req_data[(i*8+j)*W +: W] = ops[i][j];
    req_valid = pending;
  endtask

  task automatic set_pend(input int i);
    for (int j = 0; j < 8; j++)
      ops[i][j] = ($urandom_range(3) == 0) ? {W{1'b1}} : W'($urandom_range(255));
    pending[i] = 1'b1;
  endtask

  // driver: each idle requester starts a new batch with probability pct%
  task automatic drive(input int pct);
    for (int i = 0; i < N; i++)
      if (!pending[i] && $urandom_range(99) < pct) set_pend(i);
    pack();
  endtask

  task automatic model_reset();
    m_s0_v  = 0;
    m_out_v = 0;
    m_ptr   = 0;
    exp_q.delete();
    pending = '0;
  endtask

  // scoreboard: compare this cycle's outputs, then advance the model across the next edge
  task automatic at_neg();
    bit            adv;
    logic [N-1:0]  er;
    int            g;
    int            s;
    @(negedge clk);
    adv = !m_out_v || res_ready;
    g   = -1;
    if (adv) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("res_valid", 32'(res_valid), 32'(m_out_v));
    if (m_out_v && exp_q.size() > 0) begin
      chk("res_data", 32'(res_data), 32'(exp_q[0][SW-1:0]));
      chk("res_id", 32'(res_id), 32'(exp_q[0][SW+IDW-1:SW]));
    end
    last_grant = g;
    if (m_out_v && res_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (adv) begin
      m_out_v = m_s0_v;
      m_s0_v  = (g >= 0);
    end
    if (g >= 0) begin
      s = 0;
      for (int j = 0; j < 8; j++) s += int'(ops[g][j]);
      exp_q.push_back({IDW'(g), SW'(s)});
      pending[g] = 1'b0;
`ifdef ADDER_TREE_ARB_RR_EN
      m_ptr = (g + 1) % N;
`endif
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
    pack();
  endtask

  task automatic idle(input int n);
    pending   = '0;
    res_ready = 1'b1;
    pack();
    repeat (n) begin
      at_neg();
      to_next();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    pack();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0].r = 0; vecs[0].op = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    vecs[0].exp_sum = 11'd36;
    vecs[1].r = 2; vecs[1].op = '{default: 8'hFF}; vecs[1].exp_sum = 11'd2040;
    vecs[2].r = 1; vecs[2].op = '{default: 8'h00}; vecs[2].exp_sum = 11'd0;
    vecs[3].r = 3; vecs[3].op = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3].exp_sum = 11'd1020;
    vecs[4].r = 1; vecs[4].op = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    vecs[4].exp_sum = 11'd360;

    // reset state, with every requester asserting valid
    rst_n     = 1'b0;
    res_ready = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) set_pend(i);
    pack();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_id", 32'(res_id), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    pack();

    // table-driven single batches: accept cycle, 2-cycle latency, exact sum
    for (int v = 0; v < 5; v++) begin
      res_ready = 1'b1;
      for (int j = 0; j < 8; j++) ops[vecs[v].r][j] = vecs[v].op[j];
      pending[vecs[v].r] = 1'b1;
      pack();
      at_neg();
      chk("tv_ready", 32'(req_ready), 32'(N'(1) << vecs[v].r));
      to_next();
      at_neg();
      chk("tv_not_early", 32'(res_valid), 0);
      to_next();
      at_neg();
      chk("tv_valid", 32'(res_valid), 1);
      chk("tv_sum", 32'(res_data), 32'(vecs[v].exp_sum));
      chk("tv_id", 32'(res_id), 32'(vecs[v].r));
      to_next();
    end

    // fairness: all requesters continuously valid, pointer starts at 0
    do_reset();
    res_ready = 1'b1;
    drive(100);
    for (int k = 0; k < 8; k++) begin
      at_neg();
`ifdef ADDER_TREE_ARB_RR_EN
      chk("rr_grant", 32'(last_grant), 32'(k % N));
`else
      chk("fixed_grant", 32'(last_grant), 0);
`endif
      to_next();
      drive(100);
    end

    // backpressure: output and stage 0 both full, hold res_ready low for 5 cycles
    res_ready = 1'b0;
    held_d  = '0;
    held_id = '0;
    for (int c = 0; c < 5; c++) begin
      at_neg();
      if (c == 0) begin
        held_d  = res_data;
        held_id = res_id;
      end else begin
        chk("bp_data_stable", 32'(res_data), 32'(held_d));
        chk("bp_id_stable", 32'(res_id), 32'(held_id));
      end
      chk("bp_no_ready", 32'(req_ready), 0);
      to_next();
    end
    res_ready = 1'b1;
    at_neg();
    chk("bp_recover_accept", 32'(last_grant >= 0), 1);
    to_next();
    at_neg();
    chk("bp_second_result", 32'(res_valid), 1);
    to_next();
    idle(4);

    // wrap-around: drive pointer to 3, then only requesters 1 and 3 valid
    set_pend(2);
    pack();
    at_neg();
    to_next();
    set_pend(1);
    set_pend(3);
    pack();
    at_neg();
`ifdef ADDER_TREE_ARB_RR_EN
    chk("wrap_first", 32'(last_grant), 3);
`else
    chk("wrap_first", 32'(last_grant), 1);
`endif
    to_next();
    at_neg();
`ifdef ADDER_TREE_ARB_RR_EN
    chk("wrap_second", 32'(last_grant), 1);
`else
    chk("wrap_second", 32'(last_grant), 3);
`endif
    to_next();
    set_pend(1);
    set_pend(2);
    pack();
    at_neg();
`ifdef ADDER_TREE_ARB_RR_EN
    chk("wrap_ptr_end", 32'(last_grant), 2);
`else
    chk("wrap_ptr_end", 32'(last_grant), 1);
`endif
    to_next();
    idle(4);

    // random traffic with random backpressure
    repeat (400) begin
      drive(40);
      res_ready = ($urandom_range(3) != 0);
      at_neg();
      to_next();
    end
    idle(6);
    chk("drain_empty", 32'(exp_q.size()), 0);

    // reset mid-operation with stage 0 and the output both holding batches
    res_ready = 1'b0;
    drive(100);
    repeat (3) begin
      at_neg();
      to_next();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_res_data", 32'(res_data), 0);
    model_reset();
    pack();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int j = 0; j < 8; j++) ops[1][j] = W'(j + 1);
    pending[1] = 1'b1;
    pack();
    at_neg();
    to_next();
    at_neg();
    to_next();
    at_neg();
    chk("postrst_valid", 32'(res_valid), 1);
    chk("postrst_sum", 32'(res_data), 36);
    chk("postrst_id", 32'(res_id), 1);
    to_next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_arbiter.md
# adder_tree_arbiter

Shares one pipelined 8-operand, 3-level adder tree among NUM_REQ requesters. Each requester presents a batch of eight unsigned operands with a valid/ready handshake. The arbiter grants one batch per cycle, round-robin by default, and pushes it through a 2-stage tree pipeline. The full-precision sum is returned on a single result port, tagged with the requester index and subject to downstream backpressure. It sits between several accumulation clients and the shared arithmetic resource.

## Interface
- ADDER_WIDTH, default 8: width of each operand.
- NUM_REQ, default 4: number of requesters (2..8).
- ID_W, default 2: width of the requester tag; must satisfy 2^ID_W >= NUM_REQ.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; release is synchronous to clk.
- req_valid  input  NUM_REQ  bit i set means requester i offers a batch.
- req_data  input  NUM_REQ*8*ADDER_WIDTH  requester i batch in slice [i*8*W +: 8*W]; operand j in bits [j*W +: W], j = 0..7.
- req_ready  output  NUM_REQ  one-hot or zero; bit i set means the batch from requester i is accepted this cycle.
- res_valid  output  1  result available.
- res_data  output  ADDER_WIDTH+3  sum of the eight operands.
- res_id  output  ID_W  index of the requester that produced the result.
- res_ready  input  1  downstream accepts the result.

## Operation
- Pipeline advance: adv = !res_valid || res_ready. The whole pipeline, stage 0 and the output stage, moves only when adv = 1.
- Grant logic:
  - Combinational over req_valid and the priority pointer ptr.
  - grant = the first i with req_valid[i] = 1, scanning ptr, ptr+1, … with wrap modulo NUM_REQ.
  - req_ready = grant & {NUM_REQ{adv}}.
  - req_ready may depend combinationally on req_valid and res_ready.
- Accept: a batch is accepted when req_valid[i] && req_ready[i]. On accept:
  - stage 0 captures the eight operands and i, and sets s0_valid = 1;
  - ptr becomes (i+1) mod NUM_REQ.
- No accept while adv = 1: s0_valid becomes 0 and ptr holds.
- Stage 1 (output), when adv = 1:
  - res_data <= level-3 sum of the stage-0 operands;
  - res_id <= stage-0 id;
  - res_valid <= s0_valid.
- Tree arithmetic:
  - level 1 adds pairs (0,1), (2,3), (4,5), (6,7), each W+1 bits;
  - level 2 adds the level-1 pairs, W+2 bits;
  - level 3 adds the two level-2 sums, W+3 bits.
  - No truncation and no overflow is possible.
- Stall: while res_valid && !res_ready, res_data, res_id, res_valid, stage 0 and ptr hold, and req_ready = 0.
- A requester must hold req_valid and req_data stable until accepted. The arbiter never drops a granted batch.
- When a requester deasserts req_valid before being granted, nothing is recorded.
- Reset, asserted at any time:
  - res_valid = 0, res_data = 0, res_id = 0;
  - s0_valid = 0, stage-0 operands = 0, ptr = 0;
  - all in-flight batches are discarded.
  - req_ready is 0 while rst_n = 0.

## Timing
- Latency: a batch accepted at edge E appears on res_* after edge E+1, i.e. 2 cycles with no stall.
- Throughput: one batch per cycle when res_ready is held at 1.
- Simultaneous events: when all NUM_REQ requesters assert continuously with res_ready = 1, they are granted in order ptr, ptr+1, …, one per cycle.
- A result is transferred on an edge where res_valid && res_ready. A new result may be loaded on that same edge.
- Stall recovery: with the output and stage 0 both full, res_ready rising lets both advance on the next edge, and a new accept occurs in the same cycle.

## Configuration
- ADDER_TREE_ARB_RR_EN defined: round-robin arbitration as described; ptr updates on every accept.
- ADDER_TREE_ARB_RR_EN undefined:
  - fixed priority, lowest index wins;
  - ptr is constant 0 and no pointer register is built.
  - All other behaviour is unchanged.

## Test plan
- Reset and single batch, W = 8: requester 0 presents operands 1..8. Required: req_ready[0] = 1 in that cycle; two cycles later res_valid = 1, res_data = 36, res_id = 0.
- Max values: requester 2 presents all operands = 255. Required: res_data = 2040 (11 bits) and res_id = 2.
- Round-robin fairness (RR_EN defined): all four requesters hold valid with res_ready = 1. Required: grants in order 0,1,2,3,0,… and res_id in the same order, one per cycle. With RR_EN undefined, requester 0 is granted every cycle.
- Backpressure:
  - res_ready is held at 0 for 5 cycles after the first result.
  - Required: res_data and res_id are stable, req_ready = 0 throughout, and no result is lost or duplicated.
  - On release, the two queued results emerge on consecutive cycles.
- Wrap-around: ptr = 3 and only requesters 1 and 3 are valid. Required: 3 is granted first, then 1, with ptr ending at 2.
- Reset mid-operation: rst_n is pulsed low while stage 0 and the output hold batches. Required: res_valid = 0 immediately, and the first post-reset result comes from a batch accepted after reset.
